// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : fetch PC generator with a single-entry fetch buffer
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter int unsigned          ADDR_W   = 40,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(40'h0000_0100)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [1:0]        next_pc_sel_i,
  input  logic [1:0]        sel_addr_if_i,
  input  logic [ADDR_W-1:0] jump_decode_i,
  input  logic [ADDR_W-1:0] jump_commit_i,
  input  logic [ADDR_W-1:0] jump_csr_i,
  input  logic              stall_if_i,
  input  logic              flush_if_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              resp_valid_i,
  input  logic [31:0]       resp_inst_i,
  input  logic              resp_xcpt_i,
  output logic              valid_fetch_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              xcpt_o,
  output logic              xcpt_misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_KILL = 2'd3
  } state_e;

  localparam logic [1:0] SEL_PC4    = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SRC_COMMIT = 2'b01;
  localparam logic [1:0] SRC_CSR    = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              xcpt_q, xcpt_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] jump_target;
  logic              redirect;
  logic              pc_inc;
  logic              aligned;
  logic              req_valid;

  always_comb begin
    jump_target = jump_decode_i;
    case (sel_addr_if_i)
      SRC_COMMIT: jump_target = jump_commit_i;
      SRC_CSR:    jump_target = jump_csr_i;
      default:    jump_target = jump_decode_i;
    endcase
  end

  assign redirect = (next_pc_sel_i == SEL_JUMP) | flush_if_i;
  // Sequential advance is only legal once the current instruction is buffered.
  assign pc_inc   = (next_pc_sel_i == SEL_PC4) && (state_q == S_FULL);
  assign aligned  = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    xcpt_d    = xcpt_q;
    mis_d     = mis_q;
    req_valid = 1'b0;

    if (next_pc_sel_i == SEL_JUMP) begin
      pc_d = jump_target;
    end else if (pc_inc) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    case (state_q)
      S_IDLE: begin
        req_valid = !stall_if_i && !redirect && aligned;
        if (redirect) begin
          state_d = S_IDLE;
        end else if (!aligned) begin
          state_d = S_FULL;
          inst_d  = '0;
          xcpt_d  = 1'b1;
          mis_d   = 1'b1;
        end else if (req_valid && req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid_i) begin
          if (!redirect) begin
            state_d = S_FULL;
            inst_d  = resp_inst_i;
            xcpt_d  = resp_xcpt_i;
            mis_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        // The stale response still has to drain before a new request goes out.
        if (resp_valid_i) begin
          state_d = S_IDLE;
        end
      end
      S_FULL: begin
        if (pc_inc || redirect) begin
          state_d = S_IDLE;
          inst_d  = '0;
          xcpt_d  = 1'b0;
          mis_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      xcpt_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      xcpt_q  <= xcpt_d;
      mis_q   <= mis_d;
    end
  end

  // IDLE is the reset state, so the request must also be masked by reset itself.
  assign req_valid_o       = req_valid & rstn_i;
  assign req_addr_o        = pc_q;
  assign pc_o              = pc_q;
  assign valid_fetch_o     = (state_q == S_FULL);
  assign inst_o            = inst_q;
  assign xcpt_o            = xcpt_q;
  assign xcpt_misaligned_o = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : vector table plus scoreboarded fetch stream
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  localparam int ADDR_W = 40;
  localparam logic [1:0] H = 2'b00, P4 = 2'b01, J = 2'b10;
  localparam logic [1:0] DEC = 2'b00, COM = 2'b01, CSR = 2'b10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [1:0]        next_pc_sel = H;
  logic [1:0]        sel_addr = DEC;
  logic [ADDR_W-1:0] jd = '0, jc = '0, jcs = '0;
  logic              stall = 1'b0, flush = 1'b0;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready = 1'b0;
  logic              resp_valid = 1'b0;
  logic [31:0]       resp_inst = '0;
  logic              resp_xcpt = 1'b0;
  logic              valid_fetch;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       inst;
  logic              xcpt, xmis;

  fetch_pc_unit dut (
    .clk_i(clk), .rstn_i(rstn),
    .next_pc_sel_i(next_pc_sel), .sel_addr_if_i(sel_addr),
    .jump_decode_i(jd), .jump_commit_i(jc), .jump_csr_i(jcs),
    .stall_if_i(stall), .flush_if_i(flush),
    .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(req_ready),
    .resp_valid_i(resp_valid), .resp_inst_i(resp_inst), .resp_xcpt_i(resp_xcpt),
    .valid_fetch_o(valid_fetch), .pc_o(pc), .inst_o(inst),
    .xcpt_o(xcpt), .xcpt_misaligned_o(xmis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        sel;
    logic [1:0]        src;
    logic [ADDR_W-1:0] tgt;
    logic              stall, flush, ready, rv;
    logic [31:0]       ri;
    logic              rx;
    logic              e_req;
    logic [ADDR_W-1:0] e_pc;
    logic              e_vf;
    logic [31:0]       e_inst;
    logic              e_x, e_m;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } fetch_t;

  vec_t   tbl[$];
  vec_t   exp_q[$];
  fetch_t sb_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] sel, input logic [1:0] src, input logic [ADDR_W-1:0] tgt,
    input logic st, input logic fl, input logic rd, input logic rv,
    input logic [31:0] ri, input logic rx,
    input logic e_req, input logic [ADDR_W-1:0] e_pc, input logic e_vf,
    input logic [31:0] e_inst, input logic e_x, input logic e_m);
    vec_t v;
    v.sel = sel; v.src = src; v.tgt = tgt; v.stall = st; v.flush = fl;
    v.ready = rd; v.rv = rv; v.ri = ri; v.rx = rx;
    v.e_req = e_req; v.e_pc = e_pc; v.e_vf = e_vf; v.e_inst = e_inst;
    v.e_x = e_x; v.e_m = e_m;
    return v;
  endfunction

  task automatic idle_inputs();
    next_pc_sel = H; sel_addr = DEC; stall = 1'b0; flush = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_inst = '0; resp_xcpt = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    next_pc_sel = v.sel;
    sel_addr    = v.src;
    // Unselected sources carry distinct decoys so a wrong mux leg shows up.
    jd  = (v.src == DEC || v.src == 2'b11) ? v.tgt : 40'h00_0BAD_0000;
    jc  = (v.src == COM) ? v.tgt : 40'h00_0BAD_1000;
    jcs = (v.src == CSR) ? v.tgt : 40'h00_0BAD_2000;
    stall = v.stall; flush = v.flush; req_ready = v.ready;
    resp_valid = v.rv; resp_inst = v.ri; resp_xcpt = v.rx;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk($sformatf("r%0d_req_valid", idx), 64'(req_valid), 64'(e.e_req));
    chk($sformatf("r%0d_pc", idx), 64'(pc), 64'(e.e_pc));
    chk($sformatf("r%0d_req_addr", idx), 64'(req_addr), 64'(e.e_pc));
    chk($sformatf("r%0d_valid_fetch", idx), 64'(valid_fetch), 64'(e.e_vf));
    if (e.e_vf) begin
      chk($sformatf("r%0d_inst", idx), 64'(inst), 64'(e.e_inst));
      chk($sformatf("r%0d_xcpt", idx), 64'(xcpt), 64'(e.e_x));
      chk($sformatf("r%0d_mis", idx), 64'(xmis), 64'(e.e_m));
    end
  endtask

  initial begin
    int          delivered;
    bit          pend;
    int          lat;
    logic [31:0] pend_inst;
    logic [ADDR_W-1:0] exp_pc;
    fetch_t      f;

    //            sel src tgt              st fl rd rv ri            rx | req pc               vf inst          x  m
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h100,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 1, 32'h13,       0,  0, 'h100,           0, 32'h0,        0, 0));
    tbl.push_back(mk(P4, DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  0, 'h100,           1, 32'h13,       0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  1, 'h104,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h104,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 1, 32'h00A00093, 0,  0, 'h104,           0, 32'h0,        0, 0));
    tbl.push_back(mk(J,  COM, 'h2000,        0, 0, 0, 0, 32'h0,        0,  0, 'h104,           1, 32'h00A00093, 0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  1, 'h2000,          0, 32'h0,        0, 0));
    // handshake coinciding with redirect must not issue
    tbl.push_back(mk(J,  DEC, 'h100,         0, 0, 1, 0, 32'h0,        0,  0, 'h2000,          0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h100,           0, 32'h0,        0, 0));
    tbl.push_back(mk(J,  CSR, 'h300,         0, 1, 1, 0, 32'h0,        0,  0, 'h100,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  0, 'h300,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  0, 'h300,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 1, 32'hDEADBEEF, 0,  0, 'h300,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h300,           0, 32'h0,        0, 0));
    // response and redirect in the same WAIT cycle
    tbl.push_back(mk(J,  DEC, 'h500,         0, 0, 0, 1, 32'h11111111, 0,  0, 'h300,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  1, 'h500,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h500,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 1, 0, 0, 32'h0,        0,  0, 'h500,           0, 32'h0,        0, 0));
    tbl.push_back(mk(J,  DEC, 'h700,         0, 0, 1, 0, 32'h0,        0,  0, 'h500,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 1, 32'h22222222, 0,  0, 'h700,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  1, 'h700,           0, 32'h0,        0, 0));
    // misaligned jump target
    tbl.push_back(mk(J,  COM, 'h402,         0, 0, 1, 0, 32'h0,        0,  0, 'h700,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  0, 'h402,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  0, 'h402,           1, 32'h0,        1, 1));
    tbl.push_back(mk(H,  DEC, 'h0,           1, 0, 1, 0, 32'h0,        0,  0, 'h402,           1, 32'h0,        1, 1));
    tbl.push_back(mk(J,  2'b11,'h800,        0, 0, 0, 0, 32'h0,        0,  0, 'h402,           1, 32'h0,        1, 1));
    // stall in IDLE; PC_4 outside FULL holds
    tbl.push_back(mk(P4, DEC, 'h0,           1, 0, 1, 0, 32'h0,        0,  0, 'h800,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           1, 0, 1, 0, 32'h0,        0,  0, 'h800,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'h800,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 1, 32'h12345678, 1,  0, 'h800,           0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  0, 'h800,           1, 32'h12345678, 1, 0));
    // wrap-around at the top of the address space
    tbl.push_back(mk(J,  CSR, 'hFF_FFFF_FFFC,0, 0, 0, 0, 32'h0,        0,  0, 'h800,           1, 32'h12345678, 1, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 1, 0, 32'h0,        0,  1, 'hFF_FFFF_FFFC,  0, 32'h0,        0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 1, 32'h13,       0,  0, 'hFF_FFFF_FFFC,  0, 32'h0,        0, 0));
    tbl.push_back(mk(2'b11,DEC,'h0,          0, 0, 0, 0, 32'h0,        0,  0, 'hFF_FFFF_FFFC,  1, 32'h13,       0, 0));
    tbl.push_back(mk(P4, DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  0, 'hFF_FFFF_FFFC,  1, 32'h13,       0, 0));
    tbl.push_back(mk(H,  DEC, 'h0,           0, 0, 0, 0, 32'h0,        0,  1, 'h0,             0, 32'h0,        0, 0));

    // reset state, with a ready I-cache so a leaking request would be visible
    idle_inputs();
    req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", 64'(pc), 64'h100);
    chk("rst_req_valid", 64'(req_valid), 64'h0);
    chk("rst_valid_fetch", 64'(valid_fetch), 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_xcpt", 64'(xcpt), 64'h0);
    chk("rst_mis", 64'(xmis), 64'h0);
    req_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // asynchronous reset in the middle of a transaction
    @(negedge clk);
    idle_inputs();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("midrst_pc", 64'(pc), 64'h100);
    chk("midrst_req_valid", 64'(req_valid), 64'h0);
    chk("midrst_valid_fetch", 64'(valid_fetch), 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    // scoreboarded sequential stream with random handshake and response latency
    delivered = 0;
    pend      = 1'b0;
    lat       = 0;
    pend_inst = '0;
    exp_pc    = 40'h100;
    for (int cyc = 0; cyc < 600 && delivered < 24; cyc++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (valid_fetch) begin
        if (sb_q.size() == 0) begin
          chk("stream_unexpected_fetch", 64'(pc), 64'h0);
        end else begin
          f = sb_q.pop_front();
          chk($sformatf("stream%0d_pc", delivered), 64'(pc), 64'(f.pc));
          chk($sformatf("stream%0d_inst", delivered), 64'(inst), 64'(f.inst));
        end
        next_pc_sel = P4;
        exp_pc      = exp_pc + 40'd4;
        delivered++;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          resp_valid = 1'b1;
          resp_inst  = pend_inst;
          pend       = 1'b0;
        end
      end else if (req_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          chk($sformatf("stream%0d_req_addr", delivered), 64'(req_addr), 64'(exp_pc));
          req_ready = 1'b1;
          pend_inst = exp_pc[31:0] ^ 32'h5A5A_0013;
          f.pc      = exp_pc;
          f.inst    = pend_inst;
          sb_q.push_back(f);
          pend      = 1'b1;
          lat       = $urandom_range(1, 3);
        end
      end
    end
    chk("stream_delivered", 64'(delivered), 64'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
